// File: rtl/dscope_pkg.sv
// Shared types and constants for the dscope packet transmitter.
package dscope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CNT,
        DATA,
        CSUM,
        DONE
    } pkt_state_t;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;
    // Magic word plus frame counter word precede the payload.
    localparam int unsigned HDR_WORDS     = 2;

endpackage

// File: rtl/dscope_pkt_tx_if.sv
// Sample-in / packet-out stream bundle for dscope_pkt_tx (slave = transmitter block).
interface dscope_pkt_tx_if;

    logic [15:0] i_data;
    logic        i_valid;
    logic        o_rdy;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_tx_rdy;

    modport slave (
        input  i_data,
        input  i_valid,
        output o_rdy,
        output o_data,
        output o_valid,
        input  i_tx_rdy
    );

    modport master (
        output i_data,
        output i_valid,
        input  o_rdy,
        input  o_data,
        input  o_valid,
        output i_tx_rdy
    );

endinterface

// File: rtl/dscope_pkt_tx.sv
// Packs one sync-triggered frame into MAGIC, frame counter, payload [, checksum].
// Trailing checksum word is present only when DSCOPE_PKT_CSUM_EN is defined.
module dscope_pkt_tx
    import dscope_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = 512,
    parameter logic [15:0] MAGIC       = MAGIC_DEFAULT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             i_start,
    dscope_pkt_tx_if.slave   bus,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_start_drop
);

    localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_LEN - 1);

    pkt_state_t       state_reg, state_next;
    logic [15:0]      data_reg, data_next;
    logic             valid_reg, valid_next;
    logic [15:0]      word_cnt_reg, word_cnt_next;
    logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic             slot_free;
    logic             rdy;
`ifdef DSCOPE_PKT_CSUM_EN
    logic [15:0]      csum_reg, csum_next;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            word_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
`ifdef DSCOPE_PKT_CSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            word_cnt_reg  <= word_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
`ifdef DSCOPE_PKT_CSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    // The single output register may be reloaded when empty or being drained this cycle.
    assign slot_free = ~valid_reg | bus.i_tx_rdy;

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        valid_next     = valid_reg & ~bus.i_tx_rdy;
        word_cnt_next  = word_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        rdy            = 1'b0;
`ifdef DSCOPE_PKT_CSUM_EN
        csum_next      = csum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next    = HDR;
                    word_cnt_next = '0;
`ifdef DSCOPE_PKT_CSUM_EN
                    csum_next     = '0;
`endif
                end
            end
            HDR: begin
                if (slot_free) begin
                    data_next  = MAGIC;
                    valid_next = 1'b1;
                    state_next = CNT;
                end
            end
            CNT: begin
                if (slot_free) begin
                    data_next  = 16'(frame_cnt_reg);
                    valid_next = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                rdy = slot_free;
                if (bus.i_valid && slot_free) begin
                    data_next     = bus.i_data;
                    valid_next    = 1'b1;
                    word_cnt_next = word_cnt_reg + 16'd1;
`ifdef DSCOPE_PKT_CSUM_EN
                    csum_next     = csum_reg + bus.i_data;
                    if (word_cnt_reg == LAST_IDX) state_next = CSUM;
`else
                    if (word_cnt_reg == LAST_IDX) state_next = DONE;
`endif
                end
            end
`ifdef DSCOPE_PKT_CSUM_EN
            CSUM: begin
                if (slot_free) begin
                    data_next  = csum_reg;
                    valid_next = 1'b1;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                // Packet counts as complete only once its last word has left the register.
                if (slot_free) begin
                    frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.o_data   = data_reg;
    assign bus.o_valid  = valid_reg;
    assign bus.o_rdy    = rdy;
    assign o_busy       = (state_reg != IDLE);
    assign o_frame_cnt  = frame_cnt_reg;
    assign o_start_drop = i_start & (state_reg != IDLE);

endmodule

// File: tb/tb_dscope_pkt_tx.sv
// Randomized self-checking bench for dscope_pkt_tx against a packet-level scoreboard.
module tb_dscope_pkt_tx;
    import dscope_pkg::*;

    localparam int          L     = 4;
    localparam logic [15:0] MAGIC = 16'hA55A;
    localparam int          NSRC  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        o_busy;
    logic        o_start_drop;
    logic [15:0] o_frame_cnt;

    dscope_pkt_tx_if bus();

    dscope_pkt_tx #(.PAYLOAD_LEN(L), .MAGIC(MAGIC), .CNT_W(16)) dut (
        .sys_clk      (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt),
        .o_start_drop (o_start_drop)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat_due = -1;
    int          pkt_num = 0;
    logic [15:0] src [NSRC];
    int          drv_ptr = 0;
    int          mdl_ptr = 0;
    logic [15:0] exp_q [$];
    bit          busy_m = 1'b0;
    logic [15:0] fcnt_m = '0;
    bit          seen_rdy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected packet built straight from the packet format rules.
    task automatic open_packet();
        logic [15:0] sum = '0;
        logic [15:0] w;
        exp_q.push_back(MAGIC);
        exp_q.push_back(fcnt_m);
        for (int i = 0; i < L; i++) begin
            w = src[(mdl_ptr + i) % NSRC];
            exp_q.push_back(w);
            sum = sum + w;
        end
        mdl_ptr += L;
`ifdef DSCOPE_PKT_CSUM_EN
        exp_q.push_back(sum);
`else
        if (sum == 16'h0) sum = 16'h0;
`endif
        busy_m = 1'b1;
    endtask

    task automatic step(input int p_valid, input int p_tx, input int p_start);
        bit          accept;
        bit          done_now;
        logic [15:0] exp_w;
        @(negedge clk);
        bus.i_valid  = ($urandom_range(99) < p_valid);
        bus.i_tx_rdy = ($urandom_range(99) < p_tx);
        i_start      = ($urandom_range(99) < p_start);
        bus.i_data   = src[drv_ptr % NSRC];
        #3;
        done_now = 1'b0;
        check_eq("busy", 32'(o_busy), 32'(busy_m));
        check_eq("frame_cnt", 32'(o_frame_cnt), 32'(fcnt_m));
        check_eq("start_drop", 32'(o_start_drop), 32'(i_start & busy_m));
        if (!busy_m) check_eq("rdy_idle", 32'(bus.o_rdy), 32'(0));
        if (cyc == lat_due) begin
            check_eq("lat_valid", 32'(bus.o_valid), 32'(1));
            check_eq("lat_magic", 32'(bus.o_data), 32'(MAGIC));
        end
        if (bus.o_valid && bus.i_tx_rdy) begin
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            check_eq("word", 32'(bus.o_data), (exp_q.size() >= 0 && exp_w !== 16'hxxxx) ? 32'(exp_w) : 32'hDEAD_BEEF);
            done_now = busy_m && (exp_q.size() == 0);
        end
        if (bus.i_valid && bus.o_rdy) begin
            drv_ptr++;
            seen_rdy = 1'b1;
        end
        accept = i_start && !busy_m;
        if (done_now) begin
            $display("pkt %0d complete: cnt_word=%04h len=%0d", pkt_num, fcnt_m, HDR_WORDS + L);
            busy_m = 1'b0;
            fcnt_m = fcnt_m + 16'd1;
            pkt_num++;
        end
        if (accept) begin
            open_packet();
            if (p_tx == 100) lat_due = cyc + 2;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run_packet(input int p_valid, input int p_tx, input int p_start_busy);
        step(p_valid, p_tx, 100);
        for (int n = 0; n < 400 && busy_m; n++) step(p_valid, p_tx, p_start_busy);
        check_eq("pkt_timeout", 32'(busy_m), 32'(0));
    endtask

    initial begin
        src[0] = 16'h0001; src[1] = 16'h0002; src[2] = 16'h0003; src[3] = 16'h0004;
        src[4] = 16'hFFFF; src[5] = 16'h0002; src[6] = 16'h0000; src[7] = 16'h0000;
        for (int i = 8; i < NSRC; i++) src[i] = 16'($urandom);
        bus.i_valid = 1'b0; bus.i_tx_rdy = 1'b0; bus.i_data = '0;

        #2;
        check_eq("rst_data", 32'(bus.o_data), 32'(0));
        check_eq("rst_valid", 32'(bus.o_valid), 32'(0));
        check_eq("rst_rdy", 32'(bus.o_rdy), 32'(0));
        check_eq("rst_busy", 32'(o_busy), 32'(0));
        check_eq("rst_cnt", 32'(o_frame_cnt), 32'(0));
        check_eq("rst_drop", 32'(o_start_drop), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        step(100, 100, 0);
        run_packet(100, 100, 0);
        run_packet(100, 50, 30);
        run_packet(70, 70, 0);

        // Async reset while the payload is being accepted.
        seen_rdy = 1'b0;
        step(100, 100, 100);
        for (int n = 0; n < 50 && !seen_rdy; n++) step(100, 100, 0);
        check_eq("reach_data", 32'(seen_rdy), 32'(1));
        #2;
        i_start = 1'b0;
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data", 32'(bus.o_data), 32'(0));
        check_eq("arst_valid", 32'(bus.o_valid), 32'(0));
        check_eq("arst_rdy", 32'(bus.o_rdy), 32'(0));
        check_eq("arst_busy", 32'(o_busy), 32'(0));
        check_eq("arst_cnt", 32'(o_frame_cnt), 32'(0));
        check_eq("arst_drop", 32'(o_start_drop), 32'(0));
        exp_q.delete();
        busy_m = 1'b0;
        fcnt_m = '0;
        mdl_ptr = drv_ptr;
        lat_due = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_packet(100, 100, 0);
        for (int n = 0; n < 1500; n++) step(60, 60, 4);
        for (int n = 0; n < 400 && busy_m; n++) step(100, 100, 0);
        check_eq("drain_busy", 32'(busy_m), 32'(0));
        check_eq("drain_q", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dscope_pkt_tx.md
Name: dscope_pkt_tx

Overview:
Downstream stage of dscope_main. Takes the 16-bit sample stream that dscope_main emits under i_out_rdy backpressure and packs one sync-triggered frame into a packet: magic word, frame counter, fixed-length payload, optional checksum. The packet goes out as a 16-bit valid/ready stream to the link transmitter, whose ready is what drives dscope_main's i_out_rdy.

Parameters:
PAYLOAD_LEN, 512, sample words per packet (range 1..65535)
MAGIC, 16'hA55A, first word of every packet
CNT_W, 16, frame counter width (≤16; zero-extended into the counter word)

Ports:
sys_clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
i_start  in  1  frame start pulse (synchronised i_sync), sampled on sys_clk
i_data  in  16  sample word from dscope_main
i_valid  in  1  i_data valid
o_rdy  out  1  sample accepted when i_valid & o_rdy
o_data  out  16  packet word to transmitter
o_valid  out  1  o_data valid
i_tx_rdy  in  1  transmitter ready; word transfers on o_valid & i_tx_rdy
o_busy  out  1  packet in progress (state != IDLE)
o_frame_cnt  out  CNT_W  count of packets completed
o_start_drop  out  1  one-cycle pulse: i_start ignored because busy

Behaviour:
- Reset, async on rst_n low: state IDLE, o_data=0, o_valid=0, o_rdy=0, o_busy=0, o_frame_cnt=0, o_start_drop=0, word counter=0, checksum=0. Reset asserted mid-packet aborts the packet; nothing is flushed.
- Output stage is one register. It may load when ~o_valid | i_tx_rdy ("slot free"). o_valid stays high and o_data stays stable until i_tx_rdy.
- FSM:
  - IDLE: i_start=1 -> HDR. Clear checksum and word counter.
  - HDR: when slot free, load MAGIC, assert o_valid -> CNT.
  - CNT: when slot free, load the zero-extended o_frame_cnt -> DATA.
  - DATA: o_rdy = slot free (combinational). On i_valid & o_rdy: load i_data, checksum += i_data (mod 2^16), increment word counter. The accept of word PAYLOAD_LEN goes -> CSUM if the macro is defined, else -> DONE.
  - CSUM: when slot free, load checksum -> DONE.
  - DONE: wait until the last word is taken (~o_valid, or o_valid & i_tx_rdy). That cycle: o_frame_cnt++ (wraps at 2^CNT_W) -> IDLE.
- o_rdy is 0 outside DATA. Samples offered early or late are backpressured, never dropped.
- Latency: i_start at cycle N -> MAGIC valid at N+2 (one cycle in HDR, then registered), provided the transmitter is ready.
- i_start while state != IDLE: ignored, o_start_drop=1 for that cycle.
- i_start in the same cycle as the DONE->IDLE transition: ignored and flagged. The next i_start is accepted.
- i_tx_rdy low holds the FSM in place with o_data stable. Throughput is 1 word/cycle when i_valid and i_tx_rdy are continuously high.
- PAYLOAD_LEN=1: DATA accepts exactly one word.

Optional Feature:
DSCOPE_PKT_CSUM_EN
- Defined: CSUM state present. Packet = PAYLOAD_LEN+3 words; last word = 16-bit wrap-around sum of payload words.
- Undefined: CSUM state and checksum register absent. Packet = PAYLOAD_LEN+2 words. DATA goes -> DONE directly.

Decomposition:
- Package dscope_pkg: FSM state enum (IDLE, HDR, CNT, DATA, CSUM, DONE), default MAGIC constant, header word count constant (2).
- Single module, no sub-module. The output register slot logic is small enough to stay inline.

Test Plan:
- Basic, macro on, PAYLOAD_LEN=4, i_tx_rdy=1: i_start, then samples 1,2,3,4 -> o_data sequence A55A, 0000, 0001, 0002, 0003, 0004, 000A; o_frame_cnt 0->1 after the last transfer.
- Backpressure: i_tx_rdy low for 3 cycles mid-payload -> o_data/o_valid held, o_rdy=0, no sample lost or duplicated. Same sequence as above.
- Checksum wrap: samples FFFF, 0002, 0000, 0000 -> checksum word 0001.
- Start while busy: second i_start during DATA -> o_start_drop=1 for one cycle, packet unchanged. A third i_start after IDLE -> counter word 0001.
- Async reset asserted during DATA -> all outputs 0 immediately. After release, the next i_start yields counter word 0000.
- Macro off, PAYLOAD_LEN=1: sample 1234 -> A55A, 0000, 1234, then IDLE; o_frame_cnt=1.
